timer_multi: RTL and testbench



---
 rtl/timer_pkg.sv | 15 +
 rtl/timer_channel.sv | 81 ++++++++
 rtl/timer_multi.sv | 73 +++++++
 tb/tb_timer_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel countdown timer: channel mode
// encodings and the helper that locates a channel's field in a packed bus.
package timer_pkg;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  // LSB position of channel idx inside a bus of back-to-back width-bit fields.
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: loads on start, decrements on prescaler ticks,
// expires in one-shot or auto-reload periodic mode.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             periodic_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             done_o,
  output logic             running_o,
  output logic             expire_o,
  output logic [WIDTH-1:0] remaining_o
);

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  mode_e            mode_reg, mode_next;
  logic             running_reg, running_next;
  logic             expire_reg, expire_next;

  // Priority: stop, then start, then tick; a start swallows any same-cycle tick.
  always_comb begin
    cnt_next     = cnt_reg;
    reload_next  = reload_reg;
    mode_next    = mode_reg;
    running_next = running_reg;
    expire_next  = 1'b0;
    if (stop_i) begin
      cnt_next     = CNT_ZERO;
      running_next = 1'b0;
    end else if (start_i) begin
      cnt_next     = count_i;
      reload_next  = count_i;
      mode_next    = periodic_i ? MODE_PERIODIC : MODE_ONESHOT;
      running_next = (count_i != CNT_ZERO);
    end else if (tick_i) begin
      if (cnt_reg > CNT_ONE) begin
        cnt_next = cnt_reg - CNT_ONE;
      end else if (cnt_reg == CNT_ONE && running_reg) begin
        expire_next = 1'b1;
        if (mode_reg == MODE_PERIODIC) begin
          cnt_next = reload_reg;
        end else begin
          cnt_next     = CNT_ZERO;
          running_next = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_reg     <= CNT_ZERO;
      reload_reg  <= CNT_ZERO;
      mode_reg    <= MODE_ONESHOT;
      running_reg <= 1'b0;
      expire_reg  <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      reload_reg  <= reload_next;
      mode_reg    <= mode_next;
      running_reg <= running_next;
      expire_reg  <= expire_next;
    end
  end

  assign done_o      = (cnt_reg == CNT_ZERO);
  assign running_o   = running_reg;
  assign expire_o    = expire_reg;
  assign remaining_o = cnt_reg;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel countdown timer: a shared free-running prescaler with global
// pause drives NUM_CH independent timer_channel instances.
module timer_multi
  import timer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_CH  = 4,
  parameter int PRESC_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       start_i,
  input  logic [NUM_CH-1:0]       stop_i,
  input  logic [NUM_CH-1:0]       periodic_i,
  input  logic [NUM_CH*WIDTH-1:0] count_i,
  input  logic [PRESC_W-1:0]      prescale_i,
  input  logic                    pause_i,
  output logic [NUM_CH-1:0]       done_o,
  output logic [NUM_CH-1:0]       running_o,
  output logic [NUM_CH-1:0]       expire_o,
  output logic [NUM_CH*WIDTH-1:0] remaining_o
);

  localparam logic [PRESC_W-1:0] PRESC_ZERO = '0;
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  logic [PRESC_W-1:0] presc_cnt_reg, presc_cnt_next;
  logic               tick;

  assign tick = (presc_cnt_reg == PRESC_ZERO) && !pause_i;

  // The reload value is only sampled at wrap, so a new prescale_i takes
  // effect at the next tick rather than mid-period.
  always_comb begin
    presc_cnt_next = presc_cnt_reg;
    if (!pause_i) begin
      if (presc_cnt_reg == PRESC_ZERO) begin
        presc_cnt_next = prescale_i;
      end else begin
        presc_cnt_next = presc_cnt_reg - PRESC_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt_reg <= PRESC_ZERO;
    end else begin
      presc_cnt_reg <= presc_cnt_next;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam int unsigned LSB = field_lsb(gi, WIDTH);

    timer_channel #(
      .WIDTH (WIDTH)
    ) u_channel (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .tick_i      (tick),
      .start_i     (start_i[gi]),
      .stop_i      (stop_i[gi]),
      .periodic_i  (periodic_i[gi]),
      .count_i     (count_i[LSB +: WIDTH]),
      .done_o      (done_o[gi]),
      .running_o   (running_o[gi]),
      .expire_o    (expire_o[gi]),
      .remaining_o (remaining_o[LSB +: WIDTH])
    );
  end

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_timer_multi;

  localparam int WIDTH   = 8;
  localparam int NUM_CH  = 4;
  localparam int PRESC_W = 8;

  logic                    clk_i;
  logic                    rst_ni;
  logic [NUM_CH-1:0]       start_i;
  logic [NUM_CH-1:0]       stop_i;
  logic [NUM_CH-1:0]       periodic_i;
  logic [NUM_CH*WIDTH-1:0] count_i;
  logic [PRESC_W-1:0]      prescale_i;
  logic                    pause_i;
  logic [NUM_CH-1:0]       done_o;
  logic [NUM_CH-1:0]       running_o;
  logic [NUM_CH-1:0]       expire_o;
  logic [NUM_CH*WIDTH-1:0] remaining_o;

  timer_multi #(
    .WIDTH   (WIDTH),
    .NUM_CH  (NUM_CH),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .periodic_i  (periodic_i),
    .count_i     (count_i),
    .prescale_i  (prescale_i),
    .pause_i     (pause_i),
    .done_o      (done_o),
    .running_o   (running_o),
    .expire_o    (expire_o),
    .remaining_o (remaining_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state: ticks left, reload, mode, armed flag, pulse.
  int m_presc;
  int m_rem [NUM_CH];
  int m_rel [NUM_CH];
  bit m_per [NUM_CH];
  bit m_run [NUM_CH];
  bit m_exp [NUM_CH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_presc = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_rem[k] = 0; m_rel[k] = 0; m_per[k] = 0; m_run[k] = 0; m_exp[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit tick;
    tick = (m_presc == 0) && !pause_i;
    if (!pause_i) m_presc = (m_presc == 0) ? int'(prescale_i) : m_presc - 1;
    for (int k = 0; k < NUM_CH; k++) begin
      m_exp[k] = 0;
      if (stop_i[k]) begin
        m_rem[k] = 0;
        m_run[k] = 0;
      end else if (start_i[k]) begin
        m_rem[k] = int'(count_i[k*WIDTH +: WIDTH]);
        m_rel[k] = m_rem[k];
        m_per[k] = periodic_i[k];
        m_run[k] = (m_rem[k] != 0);
      end else if (tick && m_rem[k] > 1) begin
        m_rem[k] = m_rem[k] - 1;
      end else if (tick && m_rem[k] == 1 && m_run[k]) begin
        m_exp[k] = 1;
        if (m_per[k]) m_rem[k] = m_rel[k];
        else begin
          m_rem[k] = 0;
          m_run[k] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0]       e_done, e_run, e_exp;
    logic [NUM_CH*WIDTH-1:0] e_rem;
    for (int k = 0; k < NUM_CH; k++) begin
      e_done[k] = (m_rem[k] == 0);
      e_run[k]  = m_run[k];
      e_exp[k]  = m_exp[k];
      e_rem[k*WIDTH +: WIDTH] = WIDTH'(m_rem[k]);
    end
    check("done", 64'(done_o), 64'(e_done));
    check("running", 64'(running_o), 64'(e_run));
    check("expire", 64'(expire_o), 64'(e_exp));
    check("remaining", 64'(remaining_o), 64'(e_rem));
  endtask

  // One clock: model follows the edge, outputs checked 1ns later, strobes drop.
  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    compare_all();
    start_i = '0;
    stop_i  = '0;
  endtask

  task automatic arm(input int ch, input int cnt, input bit per);
    start_i[ch] = 1'b1;
    periodic_i[ch] = per;
    count_i[ch*WIDTH +: WIDTH] = WIDTH'(cnt);
  endtask

  initial begin
    int n;
    int r;
    rst_ni = 1'b0;
    start_i = '0; stop_i = '0; periodic_i = '0; count_i = '0;
    prescale_i = '0; pause_i = 1'b0;
    model_reset();
    #2;
    check("rst_done", 64'(done_o), 64'({NUM_CH{1'b1}}));
    check("rst_running", 64'(running_o), 64'h0);
    check("rst_expire", 64'(expire_o), 64'h0);
    check("rst_remaining", 64'(remaining_o), 64'h0);
    #10 rst_ni = 1'b1;
    step();
    $display("scenario reset: errors=%0d", err_cnt);

    // One-shot count 25 at P=0: expire exactly 25 edges after the start edge.
    arm(0, 25, 1'b0);
    step();
    n = 0;
    while (!expire_o[0] && n < 100) begin
      step();
      n++;
    end
    check("oneshot_latency", 64'(n), 64'd25);
    check("oneshot_run_fall", 64'(running_o[0]), 64'd0);
    step();
    $display("scenario oneshot25: latency=%0d errors=%0d", n, err_cnt);

    // Periodic count 2 at P=3, then stop.
    prescale_i = 8'd3;
    arm(1, 2, 1'b1);
    step();
    for (int i = 0; i < 40; i++) step();
    stop_i[1] = 1'b1;
    step();
    for (int i = 0; i < 20; i++) step();
    check("periodic_stopped", 64'(running_o[1]), 64'd0);
    $display("scenario periodic_p3: errors=%0d", err_cnt);

    // Restart mid-count: aborted run must not expire.
    arm(2, 10, 1'b0);
    step();
    n = 0;
    while (remaining_o[2*WIDTH +: WIDTH] != 8'd4 && n < 200) begin
      step();
      n++;
    end
    check("restart_reach4", 64'(n < 200), 64'd1);
    arm(2, 3, 1'b0);
    step();
    for (int i = 0; i < 20; i++) step();
    $display("scenario restart: errors=%0d", err_cnt);

    // Same-cycle start/stop, then zero-count start.
    arm(3, 7, 1'b1);
    stop_i[3] = 1'b1;
    step();
    check("startstop_done", 64'(done_o[3]), 64'd1);
    arm(3, 0, 1'b1);
    step();
    check("zero_running", 64'(running_o[3]), 64'd0);
    for (int i = 0; i < 10; i++) step();
    $display("scenario start_stop_zero: errors=%0d", err_cnt);

    // Pause of 5 cycles delays a count-6 expiry by 5; a start during pause loads.
    prescale_i = 8'd0;
    for (int i = 0; i < 6; i++) step();
    arm(2, 6, 1'b0);
    step();
    n = 0;
    for (int i = 0; i < 2; i++) begin step(); n++; end
    pause_i = 1'b1;
    arm(0, 9, 1'b0);
    for (int i = 0; i < 5; i++) begin step(); n++; end
    check("pause_load", 64'(remaining_o[0 +: WIDTH]), 64'd9);
    pause_i = 1'b0;
    while (!expire_o[2] && n < 100) begin
      step();
      n++;
    end
    check("pause_latency", 64'(n), 64'd11);
    for (int i = 0; i < 12; i++) step();
    $display("scenario pause: latency=%0d errors=%0d", n, err_cnt);

    // Asynchronous reset mid-count on every channel.
    for (int k = 0; k < NUM_CH; k++) arm(k, 50, k[0]);
    step();
    for (int i = 0; i < 10; i++) step();
    #3 rst_ni = 1'b0;
    #1;
    check("arst_done", 64'(done_o), 64'({NUM_CH{1'b1}}));
    check("arst_running", 64'(running_o), 64'h0);
    check("arst_expire", 64'(expire_o), 64'h0);
    check("arst_remaining", 64'(remaining_o), 64'h0);
    model_reset();
    #2 rst_ni = 1'b1;
    step();
    $display("scenario async_reset: errors=%0d", err_cnt);

    // Random traffic including max count, zero count and pauses.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) prescale_i = PRESC_W'($urandom_range(0, 3));
      pause_i = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < NUM_CH; k++) begin
        start_i[k]    = ($urandom_range(0, 19) == 0);
        stop_i[k]     = ($urandom_range(0, 59) == 0);
        periodic_i[k] = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r == 0)      count_i[k*WIDTH +: WIDTH] = '0;
        else if (r == 1) count_i[k*WIDTH +: WIDTH] = {WIDTH{1'b1}};
        else if (r == 2) count_i[k*WIDTH +: WIDTH] = WIDTH'(1);
        else             count_i[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(2, 30));
      end
      step();
    end
    $display("scenario random: errors=%0d", err_cnt);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
